// File: rtl/seq_ctrl_if.sv
// Handshake/data bundle between the fetch/execute datapath and the sequencer.
// The slave modport is the sequencer side; the master modport drives the status and data inputs.
interface seq_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       icode;
  logic             in_mem;
  logic             in_inst;
  logic             hlt;
  logic [63:0]      valP;
  logic [63:0]      valC;
  logic [63:0]      valM;
  logic             cnd;
  logic             dmem_err;
  logic [63:0]      PC;
  logic             f_en;
  logic             d_en;
  logic             e_en;
  logic             m_en;
  logic             w_en;
  logic [2:0]       stat;
  logic             busy;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  start, icode, in_mem, in_inst, hlt, valP, valC, valM, cnd, dmem_err,
    output PC, f_en, d_en, e_en, m_en, w_en, stat, busy, retired
  );

  modport master (
    output start, icode, in_mem, in_inst, hlt, valP, valC, valM, cnd, dmem_err,
    input  PC, f_en, d_en, e_en, m_en, w_en, stat, busy, retired
  );
endinterface

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer: one state per clock, six cycles per retired instruction.
// No backpressure; a fetch or data-memory fault parks the FSM in STOP until reset.
module seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_ctrl_if.slave   bus
);

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WBACK, S_PCUPD, S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [63:0]      r_pc;
  logic [63:0]      w_pc_nxt;
  logic [63:0]      w_pc_sel;
  logic [2:0]       r_stat;
  logic [2:0]       w_stat_nxt;
  logic [2:0]       w_fetch_stat;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] w_ret_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_stat    <= ST_AOK;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_pc      <= w_pc_nxt;
      r_stat    <= w_stat_nxt;
      r_retired <= w_ret_nxt;
    end
  end

  // Address fault outranks an illegal opcode, which outranks a halt.
  always_comb begin
    w_fetch_stat = ST_AOK;
    if (bus.in_mem)       w_fetch_stat = ST_ADR;
    else if (bus.in_inst) w_fetch_stat = ST_INS;
    else if (bus.hlt)     w_fetch_stat = ST_HLT;
  end

  // call and taken jump go to valC, ret to valM, everything else falls through.
  always_comb begin
    w_pc_sel = bus.valP;
    if (bus.icode == 4'd8 || (bus.icode == 4'd7 && bus.cnd)) w_pc_sel = bus.valC;
    else if (bus.icode == 4'd9)                             w_pc_sel = bus.valM;
  end

  always_comb begin
    w_next     = r_state;
    w_pc_nxt   = r_pc;
    w_stat_nxt = r_stat;
    w_ret_nxt  = r_retired;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_stat_nxt = w_fetch_stat;
        w_next     = (w_fetch_stat == ST_AOK) ? S_DECODE : S_STOP;
      end
      S_DECODE:  w_next = S_EXECUTE;
      S_EXECUTE: w_next = S_MEMORY;
      S_MEMORY: begin
        if (bus.dmem_err) begin
          w_stat_nxt = ST_ADR;
          w_next     = S_STOP;
        end else begin
          w_stat_nxt = ST_AOK;
          w_next     = S_WBACK;
        end
      end
      S_WBACK: w_next = S_PCUPD;
      S_PCUPD: begin
        w_pc_nxt  = w_pc_sel;
        w_ret_nxt = r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        w_next    = S_FETCH;
      end
      S_STOP:  w_next = S_STOP;
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.f_en    = (r_state == S_FETCH);
  assign bus.d_en    = (r_state == S_DECODE);
  assign bus.e_en    = (r_state == S_EXECUTE);
  assign bus.m_en    = (r_state == S_MEMORY);
  assign bus.w_en    = (r_state == S_WBACK);
  assign bus.busy    = (r_state != S_IDLE) && (r_state != S_STOP);
  assign bus.PC      = r_pc;
  assign bus.stat    = r_stat;
  assign bus.retired = r_retired;

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboarded bench for seq_ctrl: the driver predicts each instruction's outcome,
// the monitor compares it when the DUT retires or stops.
module tb_seq_ctrl;

  localparam logic [63:0] RST_PC = 64'h100;

  typedef struct {
    bit          kind;   // 0 = retire, 1 = stop
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [31:0] ret;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mon_en;
  logic [4:0]  strb;
  logic        prev_busy;
  logic [31:0] prev_ret;
  logic [63:0] m_pc;
  logic [31:0] m_ret;
  logic [2:0]  m_stat;
  int          n_chk;
  int          n_err;
  exp_t        sbq[$];

  seq_ctrl_if #(.CNT_W(32)) bus ();

  seq_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign strb = {bus.f_en, bus.d_en, bus.e_en, bus.m_en, bus.w_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic sb_pop(input bit kind);
    exp_t e;
    if (sbq.size() == 0) begin
      check_val("sb_unexpected_event", 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      check_val("sb_kind", {63'd0, kind}, {63'd0, e.kind});
      check_val("sb_pc", bus.PC, e.pc);
      check_val("sb_stat", {61'd0, bus.stat}, {61'd0, e.stat});
      check_val("sb_retired", {32'd0, bus.retired}, {32'd0, e.ret});
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n) begin
      if (bus.retired !== prev_ret) sb_pop(1'b0);
      else if (prev_busy && !bus.busy) sb_pop(1'b1);
      check_val("strobe_onehot0", {63'd0, $onehot0(strb)}, 64'd1);
    end
    prev_ret  = bus.retired;
    prev_busy = bus.busy;
  end

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_pc", bus.PC, RST_PC);
    check_val("rst_stat", {61'd0, bus.stat}, 64'd1);
    check_val("rst_retired", {32'd0, bus.retired}, 64'd0);
    check_val("rst_strobes", {59'd0, strb}, 64'd0);
    check_val("rst_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_pc   = RST_PC;
    m_ret  = 32'd0;
    m_stat = 3'd1;
    @(posedge clk);
    #2;
    mon_en = 1'b1;
  endtask

  task automatic do_instr(input string nm, input logic [3:0] ic, input logic im, input logic ii,
                          input logic h, input logic [63:0] vp, input logic [63:0] vc,
                          input logic [63:0] vm, input logic c, input logic de);
    logic [2:0]  fs;
    logic [63:0] np;
    bus.icode = ic;  bus.in_mem = im; bus.in_inst = ii; bus.hlt = h;
    bus.valP  = vp;  bus.valC = vc;   bus.valM = vm;    bus.cnd = c;
    bus.dmem_err = de;
    fs = im ? 3'd3 : ii ? 3'd4 : h ? 3'd2 : 3'd1;
    np = (ic == 4'd8 || (ic == 4'd7 && c)) ? vc : (ic == 4'd9) ? vm : vp;
    if (fs != 3'd1)  sbq.push_back('{1'b1, m_pc, fs, m_ret});
    else if (de)     sbq.push_back('{1'b1, m_pc, 3'd3, m_ret});
    else             sbq.push_back('{1'b0, np, 3'd1, m_ret + 32'd1});
    if (!bus.busy) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check_val({nm, "_f_en"}, {59'd0, strb}, 64'b10000);
    @(posedge clk); #1;
    if (fs != 3'd1) begin
      check_val({nm, "_stop_strobes"}, {59'd0, strb}, 64'd0);
      check_val({nm, "_stop_busy"}, {63'd0, bus.busy}, 64'd0);
      m_stat = fs;
      return;
    end
    check_val({nm, "_d_en"}, {59'd0, strb}, 64'b01000);
    @(posedge clk); #1;
    check_val({nm, "_e_en"}, {59'd0, strb}, 64'b00100);
    @(posedge clk); #1;
    check_val({nm, "_m_en"}, {59'd0, strb}, 64'b00010);
    @(posedge clk); #1;
    if (de) begin
      check_val({nm, "_dmem_no_w_en"}, {59'd0, strb}, 64'd0);
      check_val({nm, "_dmem_busy"}, {63'd0, bus.busy}, 64'd0);
      m_stat = 3'd3;
      return;
    end
    check_val({nm, "_w_en"}, {59'd0, strb}, 64'b00001);
    @(posedge clk); #1;
    check_val({nm, "_pcupd_strobes"}, {59'd0, strb}, 64'd0);
    check_val({nm, "_pcupd_pc_old"}, bus.PC, m_pc);
    @(posedge clk); #1;
    m_pc  = np;
    m_ret = m_ret + 32'd1;
  endtask

  task automatic stop_hold(input string nm);
    bus.start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_val({nm, "_hold_strobes"}, {59'd0, strb}, 64'd0);
      check_val({nm, "_hold_busy"}, {63'd0, bus.busy}, 64'd0);
      check_val({nm, "_hold_pc"}, bus.PC, m_pc);
      check_val({nm, "_hold_stat"}, {61'd0, bus.stat}, {61'd0, m_stat});
    end
    bus.start = 1'b0;
  endtask

  task automatic idle_hold(input string nm);
    repeat (3) begin
      @(posedge clk); #1;
      check_val({nm, "_idle_strobes"}, {59'd0, strb}, 64'd0);
      check_val({nm, "_idle_busy"}, {63'd0, bus.busy}, 64'd0);
      check_val({nm, "_idle_pc"}, bus.PC, RST_PC);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_err = 0;
    mon_en = 1'b0; rst_n = 1'b0;
    prev_busy = 1'b0; prev_ret = 32'd0;
    bus.start = 1'b0; bus.icode = 4'd0; bus.in_mem = 1'b0; bus.in_inst = 1'b0;
    bus.hlt = 1'b0; bus.valP = '0; bus.valC = '0; bus.valM = '0;
    bus.cnd = 1'b0; bus.dmem_err = 1'b0;
    m_pc = RST_PC; m_ret = 32'd0; m_stat = 3'd1;

    do_reset();
    idle_hold("boot");

    do_instr("op6",    4'd6, 0, 0, 0, 64'h2,  64'h0,   64'h0,  1'b0, 1'b0);
    do_instr("jmp_t",  4'd7, 0, 0, 0, 64'h1A, 64'h200, 64'h0,  1'b1, 1'b0);
    do_instr("jmp_nt", 4'd7, 0, 0, 0, 64'h1A, 64'h200, 64'h0,  1'b0, 1'b0);
    do_instr("call",   4'd8, 0, 0, 0, 64'h10, 64'hC0,  64'h0,  1'b0, 1'b0);
    do_instr("ret",    4'd9, 0, 0, 0, 64'h10, 64'h0,   64'h3B, 1'b0, 1'b0);
    do_instr("wide",   4'd8, 0, 0, 0, 64'h8,  64'hFFFF_FFFF_0000_0001, 64'h0, 1'b1, 1'b0);
    do_instr("ret_w",  4'd9, 0, 0, 0, 64'h8,  64'h0, 64'h8000_0000_0000_0004, 1'b1, 1'b0);
    do_instr("memins", 4'd6, 1, 1, 0, 64'h99, 64'h0,   64'h0,  1'b0, 1'b0);
    stop_hold("memins");

    do_reset();
    do_instr("hlt",    4'd0, 0, 0, 1, 64'h1,  64'h0,   64'h0,  1'b0, 1'b0);
    stop_hold("hlt");

    do_reset();
    do_instr("ins",    4'd6, 0, 1, 1, 64'h1,  64'h0,   64'h0,  1'b0, 1'b0);

    do_reset();
    do_instr("pre_de", 4'd6, 0, 0, 0, 64'h44, 64'h0,   64'h0,  1'b0, 1'b0);
    do_instr("dmem",   4'd5, 0, 0, 0, 64'h50, 64'h0,   64'h0,  1'b0, 1'b1);
    stop_hold("dmem");

    do_reset();
    bus.icode = 4'd6; bus.valP = 64'h40; bus.dmem_err = 1'b0;
    bus.in_mem = 1'b0; bus.in_inst = 1'b0; bus.hlt = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("abort_in_exec", {59'd0, strb}, 64'b00100);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_pc", bus.PC, RST_PC);
    check_val("abort_strobes", {59'd0, strb}, 64'd0);
    check_val("abort_busy", {63'd0, bus.busy}, 64'd0);
    check_val("abort_retired", {32'd0, bus.retired}, 64'd0);
    check_val("abort_stat", {61'd0, bus.stat}, 64'd1);
    #1 rst_n = 1'b1;
    m_pc = RST_PC; m_ret = 32'd0; m_stat = 3'd1;
    idle_hold("post_abort");
    #1 mon_en = 1'b1;
    do_instr("restart", 4'd6, 0, 0, 0, 64'h55, 64'h0, 64'h0, 1'b0, 1'b0);

    check_val("sb_leftover", sbq.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
